// File: rtl/brush_stroke_writer.sv
// brush_stroke_writer
//   Write-side producer for pixelStore. Takes one paint command (centre, colour,
//   radius), expands it into a (2r+1)x(2r+1) square footprint and issues one
//   pixel write per cycle on brush/newColor/wx/wy. Offsets falling off the
//   canvas are emitted with brush=0 so the footprint length never varies.
//   Optional build macro BRUSH_CLEAR_EN adds clear_req and a full-canvas clear
//   sweep that writes colour 0.
// Ports
//   clk, reset         clock, async active-low reset
//   clear_req          (BRUSH_CLEAR_EN only) request a canvas clear
//   cmd_valid/ready    command handshake
//   cmd_x/y/color/radius  command payload (radius clamped to MAX_RADIUS)
//   brush,newColor,wx,wy  registered write port to pixelStore
//   busy               footprint or clear in progress
//   done               one-cycle pulse after the last footprint cycle
module brush_stroke_writer #(
  parameter int COORD_W    = 8,
  parameter int COLOR_W    = 3,
  parameter int CANVAS_W   = 160,
  parameter int CANVAS_H   = 120,
  parameter int MAX_RADIUS = 3
) (
  input  logic               clk,
  input  logic               reset,
`ifdef BRUSH_CLEAR_EN
  input  logic               clear_req,
`endif
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic [1:0]         cmd_radius,
  output logic               brush,
  output logic [COLOR_W-1:0] newColor,
  output logic [COORD_W-1:0] wx,
  output logic [COORD_W-1:0] wy,
  output logic               busy,
  output logic               done
);
  localparam int SW = COORD_W + 2;
  typedef logic signed [SW-1:0] scoord_t;

  localparam scoord_t     CANVAS_WS = scoord_t'(CANVAS_W);
  localparam scoord_t     CANVAS_HS = scoord_t'(CANVAS_H);
  localparam scoord_t     ONE       = scoord_t'(1);
  localparam logic [1:0]  MAXR      = 2'(MAX_RADIUS);

  typedef enum logic [1:0] {
    IDLE, PAINT, FINISH
`ifdef BRUSH_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  state_t               state;
  scoord_t              xLat, yLat, rLat, dx, dy;
  logic [COLOR_W-1:0]   colorLat;
  logic [1:0]           rSel;
  scoord_t              px, py;
  logic                 inCanvas;

`ifdef BRUSH_CLEAR_EN
  localparam logic [COORD_W-1:0] XLAST = COORD_W'(CANVAS_W - 1);
  localparam logic [COORD_W-1:0] YLAST = COORD_W'(CANVAS_H - 1);
  localparam logic [COORD_W-1:0] CONE  = COORD_W'(1);
  logic [COORD_W-1:0] cx, cy;
`endif

  always_comb begin
    rSel     = (cmd_radius > MAXR) ? MAXR : cmd_radius;
    // Signed, two bits wider than the coordinate, so x-3 and x+3 never wrap.
    px       = xLat + dx;
    py       = yLat + dy;
    inCanvas = (px >= 0) && (px < CANVAS_WS) && (py >= 0) && (py < CANVAS_HS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      brush     <= 1'b0;
      newColor  <= '0;
      wx        <= '0;
      wy        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      xLat      <= '0;
      yLat      <= '0;
      rLat      <= '0;
      dx        <= '0;
      dy        <= '0;
      colorLat  <= '0;
`ifdef BRUSH_CLEAR_EN
      cx        <= '0;
      cy        <= '0;
`endif
    end else begin
      brush <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
`ifdef BRUSH_CLEAR_EN
          // A clear wins over a paint command presented in the same cycle.
          if (clear_req) begin
            state     <= CLEAR;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            cx        <= '0;
            cy        <= '0;
          end else
`endif
          if (cmd_valid && cmd_ready) begin
            state     <= PAINT;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            xLat      <= scoord_t'({2'b00, cmd_x});
            yLat      <= scoord_t'({2'b00, cmd_y});
            colorLat  <= cmd_color;
            rLat      <= scoord_t'(rSel);
            dx        <= -scoord_t'(rSel);
            dy        <= -scoord_t'(rSel);
          end
        end
        PAINT: begin
          brush    <= inCanvas;
          wx       <= px[COORD_W-1:0];
          wy       <= py[COORD_W-1:0];
          newColor <= colorLat;
          if (dx == rLat) begin
            dx <= -rLat;
            if (dy == rLat) state <= FINISH;
            else            dy    <= dy + ONE;
          end else begin
            dx <= dx + ONE;
          end
        end
        FINISH: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
`ifdef BRUSH_CLEAR_EN
        CLEAR: begin
          brush    <= 1'b1;
          wx       <= cx;
          wy       <= cy;
          newColor <= '0;
          if (cx == XLAST) begin
            cx <= '0;
            if (cy == YLAST) state <= FINISH;
            else             cy    <= cy + CONE;
          end else begin
            cx <= cx + CONE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_brush_stroke_writer.sv
module tb_brush_stroke_writer;
  localparam int CW = 8, KW = 3, CANW = 160, CANH = 120;
  // Radius limit below the 2-bit maximum so radius-3 requests exercise the clamp.
  localparam int MAXR = 2;

  logic          clk = 1'b0, reset = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [CW-1:0] cmd_x = '0, cmd_y = '0, wx, wy;
  logic [KW-1:0] cmd_color = '0, newColor;
  logic [1:0]    cmd_radius = '0;
  logic          brush, busy, done;
`ifdef BRUSH_CLEAR_EN
  logic          clear_req = 1'b0;
`endif

  brush_stroke_writer #(.COORD_W(CW), .COLOR_W(KW), .CANVAS_W(CANW), .CANVAS_H(CANH),
                        .MAX_RADIUS(MAXR)) dut (
    .clk(clk), .reset(reset),
`ifdef BRUSH_CLEAR_EN
    .clear_req(clear_req),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_color(cmd_color), .cmd_radius(cmd_radius), .brush(brush), .newColor(newColor),
    .wx(wx), .wy(wy), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int nChecks = 0, nPass = 0;
  int writeQ[$];   // expected writes packed as x<<11 | y<<3 | colour
  int doneQ[$];    // expected busy-cycle count per stroke
  int busyCnt = 0;

  task automatic chk(string name, int act, int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Reference: walk the square footprint and keep only on-canvas pixels.
  // Returns the negedge count from accept to the done pulse.
  function automatic int pushStroke(int x, int y, int c, int r);
    int rr = (r > MAXR) ? MAXR : r;
    int n  = (2 * rr + 1) * (2 * rr + 1);
    for (int oy = -rr; oy <= rr; oy++)
      for (int ox = -rr; ox <= rr; ox++) begin
        int px = x + ox, py = y + oy;
        if (px >= 0 && px < CANW && py >= 0 && py < CANH)
          writeQ.push_back((px << 11) | (py << 3) | c);
      end
    doneQ.push_back(n + 1);
    return n + 2;
  endfunction

  // Monitor: every strobe must match the head of the write queue; every done
  // must close a stroke with the expected number of busy cycles.
  always @(negedge clk) begin
    if (!reset) busyCnt = 0;
    else begin
      if (busy) busyCnt++;
      if (brush) begin
        if (writeQ.size() == 0) chk("unexpectedWrite", ({wx, wy, newColor}), -1);
        else chk("write", int'({wx, wy, newColor}), writeQ.pop_front());
      end
      if (done) begin
        if (doneQ.size() == 0) chk("unexpectedDone", 1, 0);
        else chk("busyCycles", busyCnt, doneQ.pop_front());
        busyCnt = 0;
      end
    end
  end

  task automatic resetVals(string tag);
    chk({tag, ".brush"}, brush, 0);
    chk({tag, ".newColor"}, newColor, 0);
    chk({tag, ".wx"}, wx, 0);
    chk({tag, ".wy"}, wy, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
  endtask

  // Called at a negedge; the accept happens at the next posedge.
  task automatic issue(int x, int y, int c, int r, output int n);
    chk("readyIdle", cmd_ready, 1);
    cmd_x = CW'(x); cmd_y = CW'(y); cmd_color = KW'(c); cmd_radius = 2'(r);
    cmd_valid = 1'b1;
    n = pushStroke(x, y, c, r);
  endtask

  task automatic waitDone(int n, bit drop, bit midPulse);
    int cnt = 0;
    do begin
      @(negedge clk); cnt++;
      if (cnt == 1 && drop) begin
        cmd_valid = 1'b0;
`ifdef BRUSH_CLEAR_EN
        clear_req = 1'b0;
`endif
        // Scrambled payload must not disturb the latched stroke.
        cmd_x = CW'($urandom); cmd_y = CW'($urandom);
        cmd_color = KW'($urandom); cmd_radius = 2'($urandom);
      end
      if (midPulse && cnt == 3) begin chk("readyBusy", cmd_ready, 0); cmd_valid = 1'b1; end
      if (midPulse && cnt == 4) cmd_valid = 1'b0;
    end while (!done && cnt < 25000);
    chk("doneLatency", cnt, n);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    resetVals("reset");
    reset = 1'b1;
    @(negedge clk);

    issue(100, 100, 2, 0, n); waitDone(n, 1, 0);          // single pixel
    issue(0, 0, 5, 1, n);     waitDone(n, 1, 0);          // corner clip, 4 writes
    issue(159, 119, 7, 3, n); chk("clampLatency", n, 27); waitDone(n, 1, 0);
    issue(159, 119, 6, 2, n); waitDone(n, 1, 0);          // far corner, 9 writes
    issue(50, 60, 1, 2, n);   waitDone(n, 1, 1);          // pulse mid-stroke: ignored

    // Held cmd_valid: the same command is taken again right after done.
    issue(20, 30, 4, 1, n);   waitDone(n, 0, 0);
    chk("readyAfterDone", cmd_ready, 1);
    n = pushStroke(20, 30, 4, 1);
    waitDone(n, 1, 0);

    // Reset in the middle of an r=2 stroke.
    issue(80, 40, 3, 2, n);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) cmd_valid = 1'b0;
    end
    #1 reset = 1'b0;
    #1 resetVals("midReset");
    writeQ.delete(); doneQ.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(5, 5, 6, 2, n);     waitDone(n, 1, 0);          // restarts at (-2,-2)

    for (int k = 0; k < 40; k++) begin
      issue($urandom_range(0, 175), $urandom_range(0, 135), $urandom_range(0, 7),
            $urandom_range(0, 3), n);
      waitDone(n, 1, 0);
    end

`ifdef BRUSH_CLEAR_EN
    chk("readyIdleClr", cmd_ready, 1);
    clear_req = 1'b1;
    cmd_valid = 1'b1;   // must lose to the clear
    for (int yy = 0; yy < CANH; yy++)
      for (int xx = 0; xx < CANW; xx++) writeQ.push_back((xx << 11) | (yy << 3));
    doneQ.push_back(CANW * CANH + 1);
    waitDone(CANW * CANH + 2, 1, 0);
    chk("clearLastX", wx, CANW - 1);
    chk("clearLastY", wy, CANH - 1);
`endif

    repeat (3) @(negedge clk);
    chk("writeQEmpty", writeQ.size(), 0);
    chk("doneQEmpty", doneQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
